// File: rtl/pipe_add_pkg.sv
// Shared defaults and the stage-count helper for the segmented pipelined adder.
package pipe_add_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    function automatic int num_stages(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/pipe_add_seg.sv
// One SEG-bit slice of the pipelined adder: registered sum, carry-out and valid.
module pipe_add_seg
    import pipe_add_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           i_valid,
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic           o_valid,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout
);

    logic [SEG-1:0] r_sum;
    logic           r_cout;
    logic           r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            {r_cout, r_sum} <= {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
            r_valid         <= i_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_sum   = r_sum;
    assign o_cout  = r_cout;

endmodule

// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit adder, carry ripples one SEG-bit segment per clock.
// Define PIPE_ADD_OVF_EN to add the signed-overflow output ovf.
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = num_stages(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;

    if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_badParams
        $error("pipe_add: WIDTH must be a positive multiple of SEG");
    end

    logic              w_en;
    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_stageCin;
    logic [STAGES-1:0] w_stageVin;
    logic [SEG-1:0]    w_segA   [STAGES];
    logic [SEG-1:0]    w_segB   [STAGES];
    logic [SEG-1:0]    w_segSum [STAGES];

    // Global stall: the whole pipe advances only when the output slot can move.
    assign w_en      = out_ready | ~out_valid;
    assign in_ready  = w_en;
    assign out_valid = w_valid[LAST];
    assign cout      = w_cout[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DEPTH = STAGES - 1 - k;

        if (k == 0) begin : g_first
            assign w_segA[k]     = a[SEG-1:0];
            assign w_segB[k]     = b[SEG-1:0];
            assign w_stageCin[k] = cin;
            assign w_stageVin[k] = in_valid;
        end else begin : g_skew
            logic [SEG-1:0] r_skA [k];
            logic [SEG-1:0] r_skB [k];

            // Operand segment k waits k cycles so it meets its incoming carry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        r_skA[j] <= '0;
                        r_skB[j] <= '0;
                    end
                end else if (w_en) begin
                    r_skA[0] <= a[k*SEG +: SEG];
                    r_skB[0] <= b[k*SEG +: SEG];
                    for (int j = 1; j < k; j++) begin
                        r_skA[j] <= r_skA[j-1];
                        r_skB[j] <= r_skB[j-1];
                    end
                end
            end

            assign w_segA[k]     = r_skA[k-1];
            assign w_segB[k]     = r_skB[k-1];
            assign w_stageCin[k] = w_cout[k-1];
            assign w_stageVin[k] = w_valid[k-1];
        end

        pipe_add_seg #(.SEG(SEG)) u_seg (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_en),
            .i_valid (w_stageVin[k]),
            .i_a     (w_segA[k]),
            .i_b     (w_segB[k]),
            .i_cin   (w_stageCin[k]),
            .o_valid (w_valid[k]),
            .o_sum   (w_segSum[k]),
            .o_cout  (w_cout[k])
        );

        if (DEPTH == 0) begin : g_noDeskew
            assign sum[k*SEG +: SEG] = w_segSum[k];
        end else begin : g_deskew
            logic [SEG-1:0] r_dsk [DEPTH];

            // Early segments wait for the top segment so a beat leaves as one word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        r_dsk[j] <= '0;
                    end
                end else if (w_en) begin
                    r_dsk[0] <= w_segSum[k];
                    for (int j = 1; j < DEPTH; j++) begin
                        r_dsk[j] <= r_dsk[j-1];
                    end
                end
            end

            assign sum[k*SEG +: SEG] = r_dsk[DEPTH-1];
        end
    end

`ifdef PIPE_ADD_OVF_EN
    logic r_abMsb;

    // Carry into the MSB is a^b^sum at that bit, so only a^b needs keeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_abMsb <= 1'b0;
        end else if (w_en) begin
            r_abMsb <= w_segA[LAST][SEG-1] ^ w_segB[LAST][SEG-1];
        end
    end

    assign ovf = w_cout[LAST] ^ r_abMsb ^ w_segSum[LAST][SEG-1];
`endif

endmodule

// File: tb/tb_pipe_add.sv
// Directed self-checking bench for pipe_add (32/8 and 8/8 configurations).
module tb_pipe_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] sum;
    logic        cout;

    logic        inValid8 = 1'b0;
    logic        inReady8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        outValid8;
    logic [7:0]  sum8;
    logic        cout8;
`ifdef PIPE_ADD_OVF_EN
    logic        ovf;
    logic        ovf8;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_add #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipe_add #(.WIDTH(8), .SEG(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid8),
        .in_ready  (inReady8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (outValid8),
        .out_ready (1'b1),
        .sum       (sum8),
        .cout      (cout8)
`ifdef PIPE_ADD_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    // Directed streaming vectors; expected {cout,sum} worked out by hand.
    logic [31:0] sA [16] = '{32'h00000000, 32'h00000000, 32'h000000FF, 32'h0000FFFF,
                             32'h00FFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678,
                             32'h89ABCDEF, 32'hF0F0F0F0, 32'h7FFFFFFF, 32'h00FF00FF,
                             32'hDEADBEEF, 32'h0000FF00, 32'h40000000, 32'h01010101};
    logic [31:0] sB [16] = '{32'h00000000, 32'h00000000, 32'h00000001, 32'h00000001,
                             32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h11111111,
                             32'h10000000, 32'h0F0F0F0F, 32'h00000001, 32'h00010001,
                             32'h00000001, 32'h00000100, 32'hC0000000, 32'hFEFEFEFE};
    logic        sCin [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [32:0] sExp [16] = '{33'h000000000, 33'h000000001, 33'h000000100, 33'h000010000,
                               33'h001000000, 33'h1FFFFFFFF, 33'h100000000, 33'h023456789,
                               33'h099ABCDEF, 33'h100000000, 33'h080000000, 33'h001000100,
                               33'h0DEADBEF1, 33'h000010000, 33'h100000000, 33'h0FFFFFFFF};

    logic [31:0] pA [5] = '{32'h00000001, 32'h000000FF, 32'hFFFF0000, 32'h11111111, 32'hFFFFFFFF};
    logic [31:0] pB [5] = '{32'h00000002, 32'h00000001, 32'h00010000, 32'h22222222, 32'h00000000};
    logic        pCin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [32:0] pExp [5] = '{33'h000000003, 33'h000000100, 33'h100000000, 33'h033333334, 33'h100000000};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] av, input logic [31:0] bv, input logic c);
        inValid = v;
        a       = av;
        b       = bv;
        cin     = c;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_sum_cout", {cout, sum}, 0);
        checkOutput("rst8_out_valid", outValid8, 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", inReady, 1);

        // Carry ripple across all four segments, latency 4 edges
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("ripple_valid_e0", outValid, 0);
        tick();
        checkOutput("ripple_valid_e1", outValid, 0);
        tick();
        checkOutput("ripple_valid_e2", outValid, 0);
        tick();
        checkOutput("ripple_valid_e3", outValid, 1);
        checkOutput("ripple_result", {cout, sum}, 33'h100000000);
        tick();
        checkOutput("ripple_drain", outValid, 0);

        // Back-to-back streaming, results in order
        for (int c = 0; c < 19; c++) begin
            if (c < 16) applyStimulus(1'b1, sA[c], sB[c], sCin[c]);
            else        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            if (c >= 3) begin
                checkOutput($sformatf("stream_valid%0d", c - 3), outValid, 1);
                checkOutput($sformatf("stream_result%0d", c - 3), {cout, sum}, sExp[c - 3]);
            end
        end
        tick();
        checkOutput("stream_drain", outValid, 0);

        // Backpressure: fill, stall 5 cycles, resume
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pA[i], pB[i], pCin[i]);
            tick();
        end
        outReady = 1'b0;
        applyStimulus(1'b1, pA[4], pB[4], pCin[4]);
        #1;
        checkOutput("bp_in_ready_drop", inReady, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp_in_ready%0d", i), inReady, 0);
            checkOutput($sformatf("bp_valid%0d", i), outValid, 1);
            checkOutput($sformatf("bp_hold%0d", i), {cout, sum}, pExp[0]);
        end
        outReady = 1'b1;
        #1;
        checkOutput("bp_in_ready_back", inReady, 1);
        for (int i = 1; i < 5; i++) begin
            tick();
            if (i == 1) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
            checkOutput($sformatf("bp_resume_valid%0d", i), outValid, 1);
            checkOutput($sformatf("bp_resume%0d", i), {cout, sum}, pExp[i]);
        end
        tick();
        checkOutput("bp_drain", outValid, 0);

        // Reset mid-flight discards everything in the pipe
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h00000005 + i, 32'h00000006, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("mid_valid_before_rst", outValid, 1);
        checkOutput("mid_result_before_rst", {cout, sum}, 33'h00000000B);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", outValid, 0);
        checkOutput("mid_rst_result", {cout, sum}, 0);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", inReady, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("mid_no_stale%0d", i), outValid, 0);
        end

        // STAGES=1 configuration
        inValid8 = 1'b1;
        a8       = 8'h80;
        b8       = 8'h80;
        cin8     = 1'b1;
        tick();
        inValid8 = 1'b0;
        checkOutput("cfg8_valid", outValid8, 1);
        checkOutput("cfg8_result", {cout8, sum8}, 9'h101);
`ifdef PIPE_ADD_OVF_EN
        checkOutput("cfg8_ovf", ovf8, 1);
`endif
        tick();
        checkOutput("cfg8_drain", outValid8, 0);

`ifdef PIPE_ADD_OVF_EN
        // Signed overflow flag
        applyStimulus(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("ovf_pos_result", {cout, sum}, 33'h080000000);
        checkOutput("ovf_pos", ovf, 1);
        tick();
        checkOutput("ovf_neg_result", {cout, sum}, 33'h100000000);
        checkOutput("ovf_neg", ovf, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
